modulo_condicionador_botoes: RTL and testbench
==============================================

# modulo_condicionador_botoes

Input-conditioning stage that sits directly upstream of the filling/corking controller. It takes the raw active-low push-buttons (operator cork load, cork transfer, cork clear) and produces synchronized, debounced levels plus one-clock press/release pulses. It also produces an optional auto-repeat press train for buttons held down. Its outputs replace the ad-hoc level-to-pulse converters on the operator inputs of the controller.

## Interface
- N_CH, 3, number of button channels (bit 0 = op_c, 1 = op, 2 = op_clr)
- CNT_W, 16, width of the per-channel debounce/repeat counters
- DEB_TICKS, 20, consecutive stable ticks needed to accept a level change (1 ≤ DEB_TICKS < 2^CNT_W)
- REPEAT_MASK, 3'b001, per-channel auto-repeat enable
- REPEAT_DELAY, 500, ticks from accepted press to first repeat pulse
- REPEAT_PERIOD, 100, ticks between subsequent repeat pulses
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk sample strobe from the frequency divider; debounce/repeat timing counts ticks only
- btn_n  in  N_CH  raw buttons, active-low, asynchronous to clk
- level  out  N_CH  debounced button state, active-high (1 = pressed)
- press  out  N_CH  one-clk pulse on accepted press and on each repeat
- release  out  N_CH  one-clk pulse on accepted release

## Operation
- Per channel: 2-FF synchronizer on btn_n, inverted to active-high `s`; no other logic touches btn_n.
- Per-channel FSM, states IDLE, PRESS_DEB, HELD, RELEASE_DEB.
  - IDLE (level=0): on tick with s=1 → PRESS_DEB, cnt=1 (if DEB_TICKS=1, go straight to HELD).
  - PRESS_DEB: on tick with s=1, cnt++; when cnt reaches DEB_TICKS → HELD, level←1, press pulse, rep_cnt=0. On tick with s=0 → IDLE, cnt=0 (bounce rejected).
  - HELD (level=1): on tick with s=0 → RELEASE_DEB, cnt=1. On tick with s=1 and REPEAT_MASK[i]: rep_cnt++. First repeat press when rep_cnt reaches REPEAT_DELAY, then each REPEAT_PERIOD ticks. rep_cnt saturates/reloads so it never wraps.
  - RELEASE_DEB: symmetric. After DEB_TICKS ticks of s=0 → IDLE, level←0, release pulse. A tick with s=1 → back to HELD, level unchanged, no press, repeat counter retained.
- Repeat count pauses during RELEASE_DEB.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Ticks are ignored while no state change is pending. `cnt` never exceeds DEB_TICKS.

## Timing
- Reset: level=0, press=0, release=0, FSMs IDLE, counters 0. Synchronizer FFs reset to the released value (btn_n=1) so that reset never creates an edge.
- A button held through reset is re-debounced. It produces a fresh press DEB_TICKS ticks after the synchronized value is first sampled.
- Latency: 2 clk synchronizer + DEB_TICKS ticks. level, press and release are registered and change in the clk cycle after the accepting tick. press coincides with the first cycle of level=1. release coincides with the first cycle of level=0.
- press/release are exactly one clk wide regardless of tick rate.
- Repeat pulse n (n≥1) occurs REPEAT_DELAY + (n-1)·REPEAT_PERIOD ticks after the initial press.
- With tick held at 0, all state freezes. No output changes except pulses clearing.

## Structure
- Shared package `pkg_condicionador`: state encoding (2-bit enum IDLE/PRESS_DEB/HELD/RELEASE_DEB) and channel index constants CH_OP_C, CH_OP, CH_OP_CLR.
- Sub-module `modulo_condicionador_canal` holds synchronizer, FSM and counters for one channel. It takes REPEAT_EN as a scalar parameter. The top generates N_CH instances.

## Test plan
- Clean press: DEB_TICKS=4, tick every 4 clk, btn_n[1] low for 40 ticks then high → level[1] rises 4 ticks after sync. One press[1] pulse, no repeat. One release[1] 4 ticks after release.
- Bounce: btn_n[0] low for 3 ticks, high 1, low 3, high → no press, level stays 0, FSM returns to IDLE.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_PERIOD=5, hold btn_n[0] for 30 ticks after acceptance → press[0] at ticks 0, 10, 15, 20, 25, 30. A held btn_n[2] yields exactly one press.
- Simultaneous: btn_n[0] and btn_n[1] fall on the same clk → press[0] and press[1] assert in the same cycle.
- Release glitch: while HELD, one tick of s=0 → no release, level stays 1, repeat timing resumes without restart.
- Reset mid-hold: assert rst during HELD with button still down → all outputs 0 next cycle. After rst deasserts, press fires again DEB_TICKS ticks after the synchronizer delay.

Source files
------------

// File: rtl/pkg_condicionador.sv
// ---------------------------------------------------------------------------
// pkg_condicionador
// Shared definitions for the operator push-button conditioning stage.
//   state_e   : per-channel debounce FSM encoding
//   CH_*      : channel index of each operator button on the btn_n bus
// ---------------------------------------------------------------------------
package pkg_condicionador;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } state_e;

    localparam int unsigned CH_OP_C   = 0;
    localparam int unsigned CH_OP     = 1;
    localparam int unsigned CH_OP_CLR = 2;

endpackage

// File: rtl/modulo_condicionador_canal.sv
// ---------------------------------------------------------------------------
// modulo_condicionador_canal
// One button channel: 2-FF synchronizer, debounce FSM and auto-repeat timer.
// All timing is counted in i_tick strobes; with i_tick low the channel freezes.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_tick    one-clk sample strobe
//   i_btn_n   raw button, active-low, asynchronous
//   o_level   debounced state, 1 = pressed
//   o_press   one-clk pulse on accepted press and on each auto-repeat
//   o_release one-clk pulse on accepted release
// Assumes DEB_TICKS >= 1, REPEAT_DELAY >= 1 and REPEAT_PERIOD >= 1.
// ---------------------------------------------------------------------------
module modulo_condicionador_canal
    import pkg_condicionador::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DEB_TICKS     = 20,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100,
    parameter bit          REPEAT_EN     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] L_DEB = CNT_W'(DEB_TICKS);
    localparam logic [CNT_W-1:0] L_DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] L_PER = CNT_W'(REPEAT_PERIOD);

    logic             r_sync1;
    logic             r_sync2;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_rep_done;   // first repeat already issued for this hold
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic             w_s;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_rep_inc;
    logic [CNT_W-1:0] w_rep_tgt;
    state_e           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_rep_cnt;
    logic             w_rep_done;
    logic             w_level;
    logic             w_press;
    logic             w_release;

    always_comb begin
        w_s        = ~r_sync2;
        // r_cnt is 0 in IDLE/HELD, so the first pending tick counts as 1 and
        // DEB_TICKS == 1 accepts straight from the stable state.
        w_cnt_inc  = r_cnt + CNT_W'(1);
        w_rep_inc  = r_rep_cnt + CNT_W'(1);
        w_rep_tgt  = r_rep_done ? L_PER : L_DLY;

        w_state    = r_state;
        w_cnt      = r_cnt;
        w_rep_cnt  = r_rep_cnt;
        w_rep_done = r_rep_done;
        w_level    = r_level;
        w_press    = 1'b0;
        w_release  = 1'b0;

        if (i_tick) begin
            unique case (r_state)
                IDLE, PRESS_DEB: begin
                    if (w_s) begin
                        if (w_cnt_inc == L_DEB) begin
                            w_state    = HELD;
                            w_cnt      = '0;
                            w_level    = 1'b1;
                            w_press    = 1'b1;
                            w_rep_cnt  = '0;
                            w_rep_done = 1'b0;
                        end else begin
                            w_state = PRESS_DEB;
                            w_cnt   = w_cnt_inc;
                        end
                    end else begin
                        w_state = IDLE;
                        w_cnt   = '0;
                    end
                end
                HELD, RELEASE_DEB: begin
                    if (!w_s) begin
                        if (w_cnt_inc == L_DEB) begin
                            w_state    = IDLE;
                            w_cnt      = '0;
                            w_level    = 1'b0;
                            w_release  = 1'b1;
                            w_rep_cnt  = '0;
                            w_rep_done = 1'b0;
                        end else begin
                            w_state = RELEASE_DEB;
                            w_cnt   = w_cnt_inc;
                        end
                    end else begin
                        w_state = HELD;
                        w_cnt   = '0;
                        // Repeat timer only runs on ticks spent stably in HELD;
                        // a bounce back from RELEASE_DEB keeps it but does not count.
                        if (REPEAT_EN && (r_state == HELD)) begin
                            if (w_rep_inc == w_rep_tgt) begin
                                w_press    = 1'b1;
                                w_rep_cnt  = '0;
                                w_rep_done = 1'b1;
                            end else begin
                                w_rep_cnt = w_rep_inc;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Released value, so leaving reset never looks like a press edge.
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rep_cnt  <= '0;
            r_rep_done <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_sync1    <= i_btn_n;
            r_sync2    <= r_sync1;
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_rep_cnt  <= w_rep_cnt;
            r_rep_done <= w_rep_done;
            r_level    <= w_level;
            r_press    <= w_press;
            r_release  <= w_release;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/modulo_condicionador_botoes.sv
// ---------------------------------------------------------------------------
// modulo_condicionador_botoes
// Conditions the operator push-buttons (bit 0 op_c, 1 op, 2 op_clr) into
// synchronized debounced levels plus one-clk press/release pulses, with
// optional auto-repeat per channel. Channels are fully independent.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_tick    one-clk sample strobe from the frequency divider
//   i_btn_n   raw buttons, active-low, asynchronous       [N_CH]
//   o_level   debounced state, 1 = pressed                [N_CH]
//   o_press   press / auto-repeat pulses                  [N_CH]
//   o_release release pulses                              [N_CH]
// ---------------------------------------------------------------------------
module modulo_condicionador_botoes #(
    parameter int unsigned          N_CH          = 3,
    parameter int unsigned          CNT_W         = 16,
    parameter int unsigned          DEB_TICKS     = 20,
    parameter logic [N_CH-1:0]      REPEAT_MASK   = 3'b001,
    parameter int unsigned          REPEAT_DELAY  = 500,
    parameter int unsigned          REPEAT_PERIOD = 100
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic [N_CH-1:0] i_btn_n,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release
);

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        modulo_condicionador_canal #(
            .CNT_W        (CNT_W),
            .DEB_TICKS    (DEB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (REPEAT_MASK[g])
        ) u_canal (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (i_tick),
            .i_btn_n  (i_btn_n[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g])
        );
    end

endmodule

// File: tb/tb_modulo_condicionador_botoes.sv
// ---------------------------------------------------------------------------
// tb_modulo_condicionador_botoes
// Table of {btn_n, ticks, expected level, expected pulses} steps plus
// hand-written sequences for auto-repeat, tick freeze and reset mid-hold.
// Expected pulses are queued with the tick number at which they must be
// accepted; a negedge monitor matches every observed pulse against the queue.
// ---------------------------------------------------------------------------
module tb_modulo_condicionador_botoes;

    localparam int unsigned N_CH = 3;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEB = 4;
    localparam int unsigned DLY = 10;
    localparam int unsigned PER = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b0;
    logic [N_CH-1:0] btn_n = '1;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;

    always #5 clk = ~clk;

    modulo_condicionador_botoes #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .DEB_TICKS    (DEB),
        .REPEAT_MASK  (3'b001),
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_tick   (tick),
        .i_btn_n  (btn_n),
        .o_level  (level),
        .o_press  (press),
        .o_release(rel)
    );

    typedef struct {
        int ch;
        bit is_rel;
        int t;
    } exp_t;

    typedef struct {
        logic [2:0] btn_n;
        int         n;
        logic [2:0] lvl;
        logic [2:0] pm;
        logic [2:0] rm;
        string      name;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[15];
    int         n_tests = 0;
    int         n_fail = 0;
    int         tick_no = 0;
    logic [2:0] prev_press = '0;
    logic [2:0] prev_rel = '0;

    task automatic check_eq(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input int ch, input bit is_rel, input int t);
        exp_t e;
        e.ch = ch;
        e.is_rel = is_rel;
        e.t = t;
        sb.push_back(e);
    endtask

    task automatic match_pulse(input int ch, input bit is_rel);
        int idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].ch == ch && sb[k].is_rel == is_rel) begin
                idx = k;
                break;
            end
        end
        if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_%s ch%0d: got pulse at tick %0d, expected none",
                     is_rel ? "release" : "press", ch, tick_no);
        end else begin
            check_eq($sformatf("%s_tick_ch%0d", is_rel ? "release" : "press", ch),
                     tick_no, sb[idx].t);
            sb.delete(idx);
        end
    endtask

    // Pulses become visible in the clk after the accepting tick, when tick_no
    // already holds that tick's number.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                if (press[i]) begin
                    match_pulse(i, 1'b0);
                    check_eq($sformatf("press_level_ch%0d", i), int'(level[i]), 1);
                end
                if (rel[i]) begin
                    match_pulse(i, 1'b1);
                    check_eq($sformatf("release_level_ch%0d", i), int'(level[i]), 0);
                end
                if (prev_press[i]) check_eq($sformatf("press_width_ch%0d", i), int'(press[i]), 0);
                if (prev_rel[i]) check_eq($sformatf("release_width_ch%0d", i), int'(rel[i]), 0);
            end
        end
        prev_press = press;
        prev_rel = rel;
    end

    // One tick per call step, every 4 clk; called and returns on a negedge.
    task automatic run_ticks(input int n);
        repeat (n) begin
            tick_no++;
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Two clk let the synchronizer settle so the next tick sees the new value.
    task automatic set_btn(input logic [2:0] v);
        btn_n = v;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0;

        vecs[0]  = '{3'b101, 3,  3'b000, 3'b000, 3'b000, "clean_deb"};
        vecs[1]  = '{3'b101, 1,  3'b010, 3'b010, 3'b000, "clean_acc"};
        vecs[2]  = '{3'b101, 36, 3'b010, 3'b000, 3'b000, "clean_hold"};
        vecs[3]  = '{3'b111, 3,  3'b010, 3'b000, 3'b000, "clean_reldeb"};
        vecs[4]  = '{3'b111, 1,  3'b000, 3'b000, 3'b010, "clean_rel"};
        vecs[5]  = '{3'b110, 3,  3'b000, 3'b000, 3'b000, "bounce_a"};
        vecs[6]  = '{3'b111, 1,  3'b000, 3'b000, 3'b000, "bounce_gap"};
        vecs[7]  = '{3'b110, 3,  3'b000, 3'b000, 3'b000, "bounce_b"};
        vecs[8]  = '{3'b111, 4,  3'b000, 3'b000, 3'b000, "bounce_idle"};
        vecs[9]  = '{3'b101, 4,  3'b010, 3'b010, 3'b000, "glitch_acc"};
        vecs[10] = '{3'b111, 1,  3'b010, 3'b000, 3'b000, "glitch_low"};
        vecs[11] = '{3'b101, 2,  3'b010, 3'b000, 3'b000, "glitch_back"};
        vecs[12] = '{3'b111, 4,  3'b000, 3'b000, 3'b010, "glitch_rel"};
        vecs[13] = '{3'b100, 4,  3'b011, 3'b011, 3'b000, "simul_acc"};
        vecs[14] = '{3'b111, 4,  3'b000, 3'b000, 3'b011, "simul_rel"};

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_level", int'(level), 0);
        check_eq("reset_press", int'(press), 0);
        check_eq("reset_release", int'(rel), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            set_btn(vecs[v].btn_n);
            for (int ch = 0; ch < N_CH; ch++) begin
                if (vecs[v].pm[ch]) expect_pulse(ch, 1'b0, tick_no + vecs[v].n);
                if (vecs[v].rm[ch]) expect_pulse(ch, 1'b1, tick_no + vecs[v].n);
            end
            run_ticks(vecs[v].n);
            check_eq({vecs[v].name, "_level"}, int'(level), int'(vecs[v].lvl));
        end

        // Auto-repeat on ch0, single press on ch2 (repeat disabled there)
        set_btn(3'b010);
        t0 = tick_no + DEB;
        expect_pulse(0, 1'b0, t0);
        expect_pulse(2, 1'b0, t0);
        for (int n = 1; n <= 5; n++) expect_pulse(0, 1'b0, t0 + DLY + (n - 1) * PER);
        run_ticks(DEB + 30);
        check_eq("repeat_level", int'(level), 5);

        // Release glitch on ch0 two ticks into a period: the low tick and the
        // tick returning to HELD do not advance the repeat count.
        run_ticks(2);
        set_btn(3'b011);
        run_ticks(1);
        check_eq("rep_glitch_level", int'(level), 5);
        set_btn(3'b010);
        expect_pulse(0, 1'b0, tick_no + 1 + (PER - 2));
        run_ticks(5);
        set_btn(3'b111);
        expect_pulse(0, 1'b1, tick_no + DEB);
        expect_pulse(2, 1'b1, tick_no + DEB);
        run_ticks(DEB + 2);
        check_eq("repeat_rel_level", int'(level), 0);

        // Tick held low freezes the debounce in progress
        set_btn(3'b110);
        expect_pulse(0, 1'b0, tick_no + DEB);
        run_ticks(2);
        repeat (60) @(negedge clk);
        check_eq("freeze_level", int'(level), 0);
        run_ticks(2);
        check_eq("freeze_acc_level", int'(level), 1);
        set_btn(3'b111);
        expect_pulse(0, 1'b1, tick_no + DEB);
        run_ticks(DEB + 2);

        // Reset while HELD: outputs clear, button re-debounced afterwards
        set_btn(3'b101);
        expect_pulse(1, 1'b0, tick_no + DEB);
        run_ticks(DEB + 2);
        check_eq("prerst_level", int'(level), 2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_level", int'(level), 0);
        check_eq("midrst_press", int'(press), 0);
        check_eq("midrst_release", int'(rel), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_btn(3'b101);
        expect_pulse(1, 1'b0, tick_no + DEB);
        run_ticks(DEB - 1);
        check_eq("postrst_deb_level", int'(level), 0);
        run_ticks(3);
        check_eq("postrst_level", int'(level), 2);
        set_btn(3'b111);
        expect_pulse(1, 1'b1, tick_no + DEB);
        run_ticks(DEB + 2);
        check_eq("final_level", int'(level), 0);

        repeat (4) @(negedge clk);
        check_eq("pending_pulses", sb.size(), 0);
        foreach (sb[k]) begin
            $display("  missing %s ch%0d at tick %0d", sb[k].is_rel ? "release" : "press",
                     sb[k].ch, sb[k].t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
